// File: rtl/ks_arith_pkg.sv
// ks_arith_pkg: types and helpers for the digit-serial Kogge-Stone adder/subtractor.
//   state_t      - sequencer states (IDLE, RUN, DONE)
//   SLICE_W      - width of the shared prefix-adder slice
//   digit_cnt_w  - width of the digit counter, at least one bit
package ks_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SLICE_W = 4;

    // A single-digit operation still needs a one-bit counter.
    function automatic int digit_cnt_w(input int num_digits);
        if (num_digits > 1) begin
            return $clog2(num_digits);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/kogge_stone_4.sv
// kogge_stone_4: combinational 4-bit Kogge-Stone adder slice.
//   a, b  - 4-bit operands
//   cin   - carry into bit 0
//   sum   - 4-bit sum
//   cout  - carry out of bit 3
module kogge_stone_4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [3:0] g_s;
    logic [3:0] p_s;
    logic [3:0] g1_s;
    logic [3:0] p1_s;
    logic [3:0] g2_s;

    // Carry-in folded into bit 0 generate so the prefix tree yields every carry directly.
    assign p_s = a ^ b;
    assign g_s = {a[3:1] & b[3:1], (a[0] & b[0]) | (p_s[0] & cin)};

    // Prefix level 1: span 2.
    assign g1_s[0] = g_s[0];
    assign p1_s[0] = p_s[0];
    assign g1_s[1] = g_s[1] | (p_s[1] & g_s[0]);
    assign p1_s[1] = p_s[1] & p_s[0];
    assign g1_s[2] = g_s[2] | (p_s[2] & g_s[1]);
    assign p1_s[2] = p_s[2] & p_s[1];
    assign g1_s[3] = g_s[3] | (p_s[3] & g_s[2]);
    assign p1_s[3] = p_s[3] & p_s[2];

    // Prefix level 2: span 4; g2_s[i] is the carry out of bit i.
    assign g2_s[0] = g1_s[0];
    assign g2_s[1] = g1_s[1];
    assign g2_s[2] = g1_s[2] | (p1_s[2] & g1_s[0]);
    assign g2_s[3] = g1_s[3] | (p1_s[3] & g1_s[1]);

    assign sum  = p_s ^ {g2_s[2:0], cin};
    assign cout = g2_s[3];

endmodule

// File: rtl/ks_serial_addsub.sv
// ks_serial_addsub: WIDTH-bit adder/subtractor that reuses one 4-bit Kogge-Stone
// slice, one nibble per cycle, with a registered carry between nibbles.
//   clk, rst             - clock, asynchronous active-high reset
//   in_valid/in_ready    - request handshake; a, b, sub, cin latched on accept
//   out_valid/out_ready  - result handshake
//   sum, cout            - result and raw final carry (subtract: 1 = no borrow)
//   overflow, zero       - signed overflow and sum==0 flags
module ks_serial_addsub
    import ks_arith_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam int NUM_DIGITS = WIDTH / SLICE_W;
    localparam int KW         = digit_cnt_w(NUM_DIGITS);
    localparam logic [KW-1:0] LAST_K = KW'(NUM_DIGITS - 1);

    state_t             state_r;
    logic [KW-1:0]      k_r;
    logic               carry_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-1:0]   res_r;
    logic               in_ready_r;
    logic               out_valid_r;
    logic [WIDTH-1:0]   sum_r;
    logic               cout_r;
    logic               overflow_r;
    logic               zero_r;

    logic [SLICE_W-1:0] slice_a_s;
    logic [SLICE_W-1:0] slice_b_s;
    logic [SLICE_W-1:0] slice_sum_s;
    logic               slice_cout_s;
    logic [WIDTH-1:0]   res_next_s;
    logic               overflow_next_s;

    kogge_stone_4 u_slice (
        .a    (slice_a_s),
        .b    (slice_b_s),
        .cin  (carry_r),
        .sum  (slice_sum_s),
        .cout (slice_cout_s)
    );

    // Select the current digit and merge the slice result into the running result.
    always_comb begin
        slice_a_s  = a_r[k_r * SLICE_W +: SLICE_W];
        slice_b_s  = b_r[k_r * SLICE_W +: SLICE_W];
        res_next_s = res_r;
        res_next_s[k_r * SLICE_W +: SLICE_W] = slice_sum_s;
        // b_r already holds ~b for subtract, so this is the usual same-sign rule.
        overflow_next_s = (a_r[WIDTH-1] == b_r[WIDTH-1]) &&
                          (res_next_s[WIDTH-1] != a_r[WIDTH-1]);
    end

    // Sequencer, operand/carry/result registers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            k_r         <= {KW{1'b0}};
            carry_r     <= 1'b0;
            a_r         <= {WIDTH{1'b0}};
            b_r         <= {WIDTH{1'b0}};
            res_r       <= {WIDTH{1'b0}};
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            sum_r       <= {WIDTH{1'b0}};
            cout_r      <= 1'b0;
            overflow_r  <= 1'b0;
            zero_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    // in_ready_r is low for the first IDLE cycle after reset.
                    if (in_valid && in_ready_r) begin
                        a_r        <= a;
                        b_r        <= sub ? ~b : b;
                        carry_r    <= cin ^ sub;
                        k_r        <= {KW{1'b0}};
                        res_r      <= {WIDTH{1'b0}};
                        in_ready_r <= 1'b0;
                        state_r    <= RUN;
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                RUN: begin
                    res_r   <= res_next_s;
                    carry_r <= slice_cout_s;
                    k_r     <= k_r + {{(KW-1){1'b0}}, 1'b1};
                    if (k_r == LAST_K) begin
                        state_r     <= DONE;
                        out_valid_r <= 1'b1;
                        sum_r       <= res_next_s;
                        cout_r      <= slice_cout_s;
                        overflow_r  <= overflow_next_s;
                        zero_r      <= (res_next_s == {WIDTH{1'b0}});
                    end else begin
                        state_r <= RUN;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    in_ready_r  <= 1'b0;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign sum       = sum_r;
    assign cout      = cout_r;
    assign overflow  = overflow_r;
    assign zero      = zero_r;

endmodule

// File: doc/ks_serial_addsub.md
Name: ks_serial_addsub

Overview:
- Multi-cycle WIDTH-bit adder/subtractor that reuses one 4-bit Kogge-Stone slice (kogge_stone_4) across successive cycles, one nibble per cycle, with a registered carry between nibbles.
- Trades latency for area in wide arithmetic paths.
- Sits between a requester using a valid/ready handshake and a consumer using a valid/ready handshake.
- Processes one operation at a time; no pipelining.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of 4 and at least 4.
- NUM_DIGITS, WIDTH/4, derived localparam: number of slice passes.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operation request.
- in_ready  output  1  block accepts a request.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sub  input  1  1 = A-B, 0 = A+B.
- cin  input  1  carry-in for add, borrow-in for subtract.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- sum  output  WIDTH  result.
- cout  output  1  raw final carry; for subtract, 1 = no borrow.
- overflow  output  1  two's-complement signed overflow.
- zero  output  1  sum == 0.

Behaviour:
- Clock/reset (already decided): one clock, clk. Reset rst is asynchronous and active-high.
- While rst is high: state=IDLE. Digit counter, carry register, operand and result registers are 0. in_ready=0, out_valid=0, sum=0, cout=0, overflow=0, zero=0.
- States and transitions:
  - IDLE: in_ready=1. When in_valid=1, the request is accepted on that edge and the state moves to RUN.
  - RUN: in_ready=0, out_valid=0.
  - DONE: out_valid=1. When out_ready=1, the state moves to IDLE.
- Accept edge:
  - Latch a_r=a.
  - Latch b_r = sub ? ~b : b.
  - carry = cin ^ sub. So add computes A+B+cin; subtract computes A-B-cin.
  - Digit counter k=0. Result register is cleared.
- RUN, each cycle:
  - The slice receives a_r[4k+3:4k], b_r[4k+3:4k] and carry.
  - The slice sum is written to res[4k+3:4k]; carry takes the slice cout.
  - k increments.
  - On the edge where k==NUM_DIGITS-1, the state moves to DONE and cout, overflow and zero are registered.
- Latency: out_valid rises exactly NUM_DIGITS cycles after the accept edge (4 cycles for WIDTH=16).
- overflow = (a_r[MSB]==b_r[MSB]) && (res[MSB]!=a_r[MSB]), evaluated on the final result.
- Output hold in DONE: sum, cout, overflow and zero stay stable until the out handshake completes.
- Leaving DONE: out_valid drops the cycle after the handshake. Outputs keep their last values while IDLE.
- in_ready is 1 only in IDLE. There is no accept on the same cycle as the out handshake, so the minimum issue interval is NUM_DIGITS+2 cycles.
- in_valid and input changes during RUN or DONE are ignored; operands are latched only at accept.
- out_ready during IDLE or RUN has no effect.
- Reset mid-RUN or mid-DONE: the operation is aborted and all outputs return to reset values asynchronously.
- WIDTH=4 corner case: a single RUN cycle, then DONE.

Decomposition:
- Shared package ks_arith_pkg:
  - state enum {IDLE, RUN, DONE}.
  - SLICE_W=4.
  - function for the digit-counter width, $clog2(NUM_DIGITS) with a minimum of 1.
- Sub-module: one instance of the existing kogge_stone_4 as the slice datapath. All sequencing, the carry register and the result register stay in ks_serial_addsub.

Test Plan:
- Basic add, latency check. WIDTH=16; a=0x1234, b=0x4321, sub=0, cin=0 → sum=0x5555, cout=0, overflow=0, zero=0. out_valid is high exactly 4 cycles after the accept edge.
- Full carry ripple. a=0xFFFF, b=0x0001, add → sum=0x0000, cout=1, zero=1, overflow=0. The carry propagates across all 4 slice passes.
- Subtract with signed overflow. a=0x8000, b=0x0001, sub=1, cin=0 → sum=0x7FFF, cout=1, overflow=1.
- Subtract with borrow, and borrow-in.
  - a=0x0000, b=0x0001, sub=1 → sum=0xFFFF, cout=0, overflow=0.
  - a=0x0005, b=0x0003, sub=1, cin=1 → sum=0x0001, cout=1.
- Backpressure and ignored input.
  - Hold out_ready=0 for 3 cycles in DONE → sum/flags stable and in_ready=0 throughout.
  - Pulse in_valid with new operands during RUN → result unaffected.
  - Set out_ready=1 → in_ready=1 on the next cycle.
- Reset mid-operation. Assert rst during RUN cycle 2 → out_valid=0 and sum=0 immediately (asynchronous). After release, a=0x00FF, b=0x0001 add → sum=0x0100, with no residue from the aborted operation.
